// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, switch-bus field layout, sequencer states.
// Imported by the op sequencer and its settle counter.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_GT   = 4'd12;
  localparam logic [3:0] OP_LT   = 4'd13;
  localparam logic [3:0] OP_EQ   = 4'd14;
  localparam logic [3:0] OP_INC  = 4'd15;

  localparam int SW_A_LSB   = 0;
  localparam int SW_B_LSB   = 4;
  localparam int SW_OP_LSB  = 8;
  localparam int SW_PAD_LSB = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } seq_state_e;

  function automatic logic [15:0] pack_sw(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] op
  );
    logic [15:0] sw;
    sw = '0;
    sw[SW_A_LSB +: 4]   = a;
    sw[SW_B_LSB +: 4]   = b;
    sw[SW_OP_LSB +: 4]  = op;
    sw[SW_PAD_LSB +: 4] = 4'h0;
    return sw;
  endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// Down-counter timing how long the ALU inputs settle.
// done_o flags the cycle whose edge should sample the ALU result.
module alu_settle_counter
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_val_i,
  output logic       done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      load_i:                  cnt_d = load_val_i;
      (dec_i && cnt_q != '0):  cnt_d = cnt_q - 4'd1;
      default:                 cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives one operation onto the ALU switch bus, waits for it to settle,
// captures the LED result and hands it out over a valid/ready response.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_a,
  input  logic [3:0]  req_b,
  input  logic [3:0]  req_op,
  output logic [15:0] alu_sw,
  input  logic [4:0]  alu_led,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_result,
  output logic [3:0]  rsp_op,
  output logic [7:0]  op_count
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  seq_state_e  state_q, state_d;
  logic [15:0] sw_q, sw_d;
  logic        vld_q, vld_d;
  logic [4:0]  res_q, res_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        st_load;
  logic        st_dec;
  logic        st_done;

  alu_settle_counter u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (st_load),
    .dec_i      (st_dec),
    .load_val_i (SETTLE_LD),
    .done_o     (st_done)
  );

  always_comb begin
    state_d = state_q;
    sw_d    = sw_q;
    vld_d   = vld_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    st_load = 1'b0;
    st_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sw_d    = pack_sw(req_a, req_b, req_op);
          op_d    = req_op;
          st_load = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        st_dec = 1'b1;
        // alu_led is only trusted on the final settle edge
        if (st_done) begin
          res_d   = alu_led;
          vld_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sw_q    <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign alu_sw     = sw_q;
  assign rsp_valid  = vld_q;
  assign rsp_result = res_q;
  assign rsp_op     = op_q;
  assign op_count   = cnt_q;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 2, number of clk cycles alu_sw is held stable before alu_led is sampled (legal range 1..15).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_a  input  4  operand A.
REQ-008 req_b  input  4  operand B.
REQ-009 req_op  input  4  ALU opcode, 0..15.
REQ-010 alu_sw  output  16  ALU switch bus: [3:0]=A, [7:4]=B, [11:8]=op, [15:12]=0.
REQ-011 alu_led  input  5  ALU result: [3:0]=result, [4]=carry/sign.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_result  output  5  captured alu_led value.
REQ-015 rsp_op  output  4  opcode of the captured transaction.
REQ-016 op_count  output  8  number of completed response handshakes.

Function
REQ-017 The FSM SHALL have states IDLE, SETTLE, RESP; reset state IDLE.
REQ-018 req_ready SHALL be 1 exactly in IDLE, decoded from state (no combinational path from rsp_ready).
REQ-019 On a clk edge in IDLE with req_valid=1, alu_sw SHALL load {4'b0, req_op, req_b, req_a}, rsp_op SHALL load req_op, settle counter SHALL load SETTLE_CYCLES, FSM SHALL go to SETTLE.
REQ-020 In SETTLE the counter SHALL decrement each edge; on the edge where it equals 1, rsp_result SHALL load alu_led, rsp_valid SHALL set, FSM SHALL go to RESP.
REQ-021 Latency: rsp_valid SHALL rise exactly SETTLE_CYCLES edges after the accepting edge (default: 2).
REQ-022 In RESP, rsp_valid, rsp_result, rsp_op SHALL hold stable until an edge with rsp_ready=1; on that edge rsp_valid SHALL clear, op_count SHALL increment, FSM SHALL go to IDLE.
REQ-023 No bypass: after a response handshake, req_ready SHALL be 1 in the following cycle; minimum request-to-request spacing SHALL be SETTLE_CYCLES+2 cycles.
REQ-024 alu_sw SHALL change only on the accepting edge and SHALL hold its last value after the response (no return to zero).
REQ-025 alu_sw[15:12] SHALL always be 0.
REQ-026 op_count SHALL wrap 255 -> 0 without any flag.
REQ-027 req_valid while not in IDLE SHALL be ignored (no capture, no error).
REQ-028 alu_led SHALL be sampled only on the REQ-020 edge; changes at other times SHALL not affect rsp_result.

Reset
REQ-029 While rst_n=0, asynchronously: state=IDLE, alu_sw=0, rsp_valid=0, rsp_result=0, rsp_op=0, op_count=0, settle counter=0.
REQ-030 Reset asserted in SETTLE or RESP SHALL discard the transaction; no response SHALL appear after release.
REQ-031 First request SHALL be accepted on the first clk edge after rst_n deasserts.

Structure
REQ-032 Shared package alu_pkg SHALL hold opcode constants (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_NAND=7, OP_NOR=8, OP_XNOR=9, OP_SHL=10, OP_SHR=11, OP_GT=12, OP_LT=13, OP_EQ=14, OP_INC=15) and alu_sw field positions.
REQ-033 The settle counter SHALL be one sub-module, alu_settle_counter (load, decrement, done at 1).
REQ-034 The FSM and response registers SHALL stay in alu_op_sequencer; alu_sw SHALL be driven only from flops.

Verification (bench instantiates alu_op_sequencer driving the gate-level ALU, SETTLE_CYCLES=2)
REQ-035 A=4, B=3, op=0, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_result=5'b00111, rsp_op=0, op_count=1.
REQ-036 A=7, B=3, op=2; then A=6, B=2, op=3 back-to-back -> rsp_result=5'b10101 then 5'b00011; second accept exactly 4 cycles after the first.
REQ-037 A=12, B=2, op=11, rsp_ready=0 for 10 cycles -> rsp_valid, rsp_result=5'b00011 stable for all 10 cycles, req_ready=0, op_count unchanged until handshake.
REQ-038 A=5, B=5, op=14; rst_n low for 1 cycle while in SETTLE -> alu_sw=0, rsp_valid never rises, op_count=0; next request completes normally.
REQ-039 256 consecutive op=15 (A=6) transactions -> each rsp_result[3:0]=4'b0111, op_count returns to 0 after the 256th.
REQ-040 req_valid held 1 continuously with changing req_a -> only values present at IDLE accept edges appear on alu_sw[3:0]; alu_sw[15:12]=0 throughout.
